// File: rtl/sha1_core_chain_if.sv
// sha1_core_chain_if: block request / digest handshake between the block feeder and the SHA-1 core.
interface sha1_core_chain_if;
   logic         start;
   logic         init;
   logic [511:0] sha1in;
   logic         ready;
   logic         done;
   logic [159:0] sha1out;
   modport master (output start, init, sha1in, input ready, done, sha1out);
   modport slave (input start, init, sha1in, output ready, done, sha1out);
endinterface

// File: rtl/sha1_core_chain.sv
// sha1_core_chain: SHA-1 compression core, RPC rounds per clock, chaining value carried across blocks.
module sha1_core_chain #(
   parameter int RPC = 1
) (
   input logic clk,
   input logic rst_n,
   sha1_core_chain_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
   localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5 || RPC == 8 || RPC == 10 || RPC == 16)) begin : g_bad_rpc
      $error("sha1_core_chain: RPC must be one of 1, 2, 4, 5, 8, 10, 16");
   end

   state_t       state, state_nx;
   logic [6:0]   t;
   logic [159:0] h, v, vr, sum, digest;
   logic         done;
   logic [31:0]  w [16];
   logic [31:0]  x [32];

   function automatic logic [31:0] rol(input logic [31:0] a, input int n);
      return (a << n) | (a >> (32 - n));
   endfunction

   function automatic logic [159:0] step(input logic [159:0] s, input logic [6:0] j, input logic [31:0] wj);
      logic [31:0] a, b, c, d, e, f, k;
      {a, b, c, d, e} = s;
      f = j < 7'd20 ? (b & c) | (~b & d) :
          j >= 7'd40 && j < 7'd60 ? (b & c) | (b & d) | (c & d) : b ^ c ^ d;
      k = j < 7'd20 ? 32'h5a827999 : j < 7'd40 ? 32'h6ed9eba1 : j < 7'd60 ? 32'h8f1bbcdc : 32'hca62c1d6;
      return {rol(a, 5) + f + e + k + wj, a, rol(b, 30), c, d};
   endfunction

   // x[0..15] is the current window W_t..W_t+15; x[16..] extends it by the RPC words needed next cycle
   always_comb begin
      for (int i = 0; i < 16; i++) x[i] = w[i];
      for (int i = 16; i < 32; i++) x[i] = i < 16 + RPC ? rol(x[i-3] ^ x[i-8] ^ x[i-14] ^ x[i-16], 1) : 32'h0;
      vr = v;
      for (int r = 0; r < RPC; r++) vr = step(vr, t + 7'(r), x[r]);
      for (int i = 0; i < 5; i++) sum[32*i +: 32] = h[32*i +: 32] + v[32*i +: 32];
   end

   always_comb begin
      state_nx = state;
      if (state == IDLE) state_nx = bus.start ? ROUND : IDLE;
      else if (state == ROUND) state_nx = t + 7'(RPC) == 7'd80 ? FINAL : ROUND;
      else state_nx = IDLE;
   end

   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h      <= IV;
         t      <= '0;
         done   <= 1'b0;
         digest <= '0;
      end else begin
         done <= state == FINAL;
         if (state == IDLE && bus.start) begin
            for (int i = 0; i < 16; i++) w[i] <= bus.sha1in[511 - 32*i -: 32];
            v <= bus.init ? IV : h;
            if (bus.init) h <= IV;
            t <= '0;
         end
         if (state == ROUND) begin
            for (int i = 0; i < 16; i++) w[i] <= x[i + RPC];
            v <= vr;
            t <= t + 7'(RPC);
         end
         if (state == FINAL) begin
            h      <= sum;
            digest <= sum;
         end
      end
   end

   assign bus.ready   = state == IDLE;
   assign bus.done    = done;
   assign bus.sha1out = digest;
endmodule

// File: doc/sha1_core_chain.md
# sha1_core_chain

Parametrised SHA-1 compression core with multi-block chaining and configurable rounds per clock. It accepts one pre-padded 512-bit block per START, processes 80 rounds in 80/RPC cycles, and accumulates the chaining value across blocks until a new message is begun with INIT. It sits between the message-padding/block feeder and the digest consumer, and it replaces the single-block, one-round-per-clock core.

## Interface
- RPC, 1: rounds computed per clock; legal values are 1, 2, 4, 5, 8, 10, 16; any other value is an elaboration error.
- CLK  input  1  single clock; all state updates on rising edge.
- nRST  input  1  reset, synchronous and active-low.
- START  input  1  block request; sampled only while READY=1.
- INIT  input  1  sampled with START; 1 = first block of a message (chain from IV), 0 = continue from the current H.
- SHA1IN  input  512  padded block, big-endian words; W0=SHA1IN[511:480] … W15=SHA1IN[31:0]; sampled only at acceptance.
- READY  output  1  core idle, able to accept START.
- DONE  output  1  one-cycle pulse: block finished, SHA1OUT updated.
- SHA1OUT  output  160  {H0,H1,H2,H3,H4} after the last completed block; held until the next DONE.

## Operation
- The IV is H0=67452301, H1=EFCDAB89, H2=98BADCFE, H3=10325476, H4=C3D2E1F0.
- Reset (nRST=0 at an edge) takes effect from any state, including mid-block; the block in progress is discarded:
  - state=IDLE, H=IV, t=0, READY=1, DONE=0, SHA1OUT=0.
- State IDLE: READY=1. If START=1 at an edge:
  - Load the 16-word W window from SHA1IN.
  - Load A..E from IV if INIT=1, else from H. If INIT=1, H is also set to IV at that edge.
  - t=0, go to ROUND.
- State ROUND: READY=0. At each edge, apply rounds t..t+RPC-1 in sequence, then t+=RPC.
  - Round j: temp = ROTL5(A) + f_j(B,C,D) + E + K_j + W_j (mod 2^32); then E=D, D=C, C=ROTL30(B), B=A, A=temp.
  - f and K are selected per round, not per cycle:
    - j 0–19: f=(B&C)|(~B&D), K=5A827999
    - j 20–39: f=B^C^D, K=6ED9EBA1
    - j 40–59: f=(B&C)|(B&D)|(C&D), K=8F1BBCDC
    - j 60–79: f=B^C^D, K=CA62C1D6
  - W_j for j≥16 = ROTL1(W_{j-3}^W_{j-8}^W_{j-14}^W_{j-16}). It is generated in a 16-word rolling window that advances RPC words per cycle; no 80-word array.
  - After the edge where t reaches 80, go to FINAL.
- State FINAL: at the edge, Hi += {A,B,C,D,E}i (each mod 2^32), SHA1OUT = new H, DONE=1, go to IDLE.
- DONE is high exactly in the cycle after the FINAL edge, and that cycle is already IDLE. A START in that cycle is accepted, so blocks can run back to back.
- START while READY=0 is ignored and not queued. INIT and SHA1IN are don't-care except at acceptance.
- INIT=0 on the first block after reset chains from IV, which gives the same result as INIT=1.

## Timing
- Acceptance edge E0. Round edges are E1…E(80/RPC). The FINAL edge is E(80/RPC+1).
- DONE=1 and the new SHA1OUT are visible in cycle E(80/RPC+1)…E(80/RPC+2). DONE falls at E(80/RPC+2) unless another FINAL occurs at that edge.
- Latency and throughput: START to DONE is 80/RPC+1 edges; block period is 80/RPC+1 cycles. For RPC=1 that is 81 cycles; for RPC=4 it is 21 cycles.
- READY falls at E0 and rises at the FINAL edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Empty message, RPC=1:
  - Stimulus: INIT=1, SHA1IN = 80000000 followed by 14 zero words, then 00000000.
  - Required: DONE exactly 81 edges after acceptance; SHA1OUT = da39a3ee5e6b4b0d3255bfef95601890afd80709.
- "abc", RPC=1,4,16:
  - Stimulus: INIT=1, SHA1IN = 61626380, 13 zero words, 00000000, 00000018.
  - Required: SHA1OUT = a9993e364706816aba3e25717850c26c9cd0d89d; DONE latency 81, 21 and 6 edges respectively.
- Two-block chaining:
  - Stimulus: the padded 448-bit message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"; block 1 with INIT=1, block 2 with INIT=0, START for block 2 asserted in block 1's DONE cycle.
  - Required: final digest matches the software SHA-1 model; there is no idle cycle between the blocks.
- INIT restart:
  - Stimulus: "abc" (INIT=0) after a completed unrelated message, then "abc" again with INIT=1.
  - Required: the first result differs from a9993e36…; the second result equals a9993e36….
- START while busy and reset mid-block:
  - Stimulus: pulse START with a different block at round 40, then assert nRST=0 for one edge at round 60.
  - Required: the extra START has no effect. After reset: READY=1, DONE=0, SHA1OUT=0, no DONE pulse. A following "abc" with INIT=0 yields a9993e36….
